// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register ids and
// the decode source/destination select used by the decode stage.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } dec_sel_t;

    function automatic dec_sel_t dec_select(
        input logic [3:0] icode,
        input logic [3:0] ra,
        input logic [3:0] rb,
        input logic       cnd
    );
        dec_sel_t s;
        s.src_a = RNONE;
        s.src_b = RNONE;
        s.dst_e = RNONE;
        s.dst_m = RNONE;
        unique case (1'b1)
            icode == I_CMOV,
            icode == I_RMMOV,
            icode == I_OPQ,
            icode == I_PUSH: s.src_a = ra;
            icode == I_RET,
            icode == I_POP:  s.src_a = RSP;
            default: ;
        endcase
        unique case (1'b1)
            icode == I_RMMOV,
            icode == I_MRMOV,
            icode == I_OPQ:  s.src_b = rb;
            icode == I_CALL,
            icode == I_RET,
            icode == I_PUSH,
            icode == I_POP:  s.src_b = RSP;
            default: ;
        endcase
        unique case (1'b1)
            icode == I_IRMOV,
            icode == I_OPQ:  s.dst_e = rb;
            icode == I_CMOV: s.dst_e = cnd ? rb : RNONE;
            icode == I_CALL,
            icode == I_RET,
            icode == I_PUSH,
            icode == I_POP:  s.dst_e = RSP;
            default: ;
        endcase
        unique case (1'b1)
            icode == I_MRMOV,
            icode == I_POP:  s.dst_m = ra;
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: 15 x 64-bit, two read ports, one debug port,
// E and M write ports with M taking priority on a shared index.
module y86_regfile
    import y86_pkg::*;
#(
    parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    input  logic [3:0]  dbg_addr,
    output logic [63:0] rd_a,
    output logic [63:0] rd_b,
    output logic [63:0] dbg_data
);

    logic [63:0] regs [15];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= (i == 4) ? STACK_INIT : 64'd0;
        end else if (we) begin
            if (dst_e != RNONE)
                regs[dst_e] <= val_e;
            // later assignment wins: M beats E
            if (dst_m != RNONE)
                regs[dst_m] <= val_m;
        end
    end

    assign rd_a     = (src_a == RNONE) ? 64'd0 : regs[src_a];
    assign rd_b     = (src_b == RNONE) ? 64'd0 : regs[src_b];
    assign dbg_data = (dbg_addr == RNONE) ? 64'd0 : regs[dbg_addr];

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/writeback stage: register select, registered
// operand read, latched destinations and writeback into the regfile.
module decode_writeback
    import y86_pkg::*;
#(
    parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        instr_valid,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    input  logic [3:0]  dbg_addr,
    output logic [63:0] dbg_data
);

    dec_sel_t    sel;
    logic [63:0] rd_a;
    logic [63:0] rd_b;
    logic [63:0] op_a;
    logic [63:0] op_b;

    assign sel = dec_select(icode, rA, rB, cnd);

    y86_regfile #(
        .STACK_INIT(STACK_INIT)
    ) u_rf (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (wb_en),
        .dst_e    (dstE),
        .val_e    (valE),
        .dst_m    (dstM),
        .val_m    (valM),
        .src_a    (sel.src_a),
        .src_b    (sel.src_b),
        .dbg_addr (dbg_addr),
        .rd_a     (rd_a),
        .rd_b     (rd_b),
        .dbg_data (dbg_data)
    );

    // forward a same-edge writeback; M has priority like the regfile
    always_comb begin
        op_a = rd_a;
        op_b = rd_b;
        if (BYPASS && wb_en) begin
            if (sel.src_a != RNONE) begin
                if (sel.src_a == dstM)
                    op_a = valM;
                else if (sel.src_a == dstE)
                    op_a = valE;
            end
            if (sel.src_b != RNONE) begin
                if (sel.src_b == dstM)
                    op_b = valM;
                else if (sel.src_b == dstE)
                    op_b = valE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valA <= 64'd0;
            valB <= 64'd0;
            dstE <= RNONE;
            dstM <= RNONE;
        end else if (instr_valid) begin
            valA <= op_a;
            valB <= op_b;
            dstE <= sel.dst_e;
            dstM <= sel.dst_m;
        end else begin
            dstE <= RNONE;
            dstM <= RNONE;
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: a BYPASS=1 and a BYPASS=0
// instance share stimulus and are checked against a behavioural model.
module tb_decode_writeback;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  icode, rA, rB, dbg_addr;
    logic        instr_valid, cnd, wb_en;
    logic [63:0] valE, valM;
    logic [63:0] va1, vb1, dd1, va0, vb0, dd0;
    logic [3:0]  de1, dm1, de0, dm0;

    always #5 clk = ~clk;

    decode_writeback #(.BYPASS(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .icode(icode), .rA(rA), .rB(rB),
        .instr_valid(instr_valid), .cnd(cnd), .valE(valE), .valM(valM),
        .wb_en(wb_en), .valA(va1), .valB(vb1), .dstE(de1), .dstM(dm1),
        .dbg_addr(dbg_addr), .dbg_data(dd1)
    );

    decode_writeback #(.BYPASS(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .icode(icode), .rA(rA), .rB(rB),
        .instr_valid(instr_valid), .cnd(cnd), .valE(valE), .valM(valM),
        .wb_en(wb_en), .valA(va0), .valB(vb0), .dstE(de0), .dstM(dm0),
        .dbg_addr(dbg_addr), .dbg_data(dd0)
    );

    typedef struct {
        logic [63:0] a1, a0, b1, b0;
        logic [3:0]  e, m;
    } exp_t;

    exp_t scb[$];
    int n_chk = 0;
    int n_err = 0;

    logic [63:0] mrf [15];
    logic [3:0]  m_e, m_m;
    logic [63:0] m_a1, m_a0, m_b1, m_b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 15; i++)
            mrf[i] = (i == 4) ? 64'h200 : 64'd0;
        m_e = 4'hF; m_m = 4'hF;
        m_a1 = 0; m_a0 = 0; m_b1 = 0; m_b0 = 0;
        scb.delete();
    endtask

    function automatic logic [63:0] m_rd(input logic [3:0] r);
        return (r == 4'hF) ? 64'd0 : mrf[r];
    endfunction

    function automatic logic [63:0] m_byp(input logic [3:0] s,
        input logic w, input logic [63:0] old, ve, vm);
        if (!w || s == 4'hF) return old;
        if (s == m_m) return vm;
        if (s == m_e) return ve;
        return old;
    endfunction

    task automatic m_sel(input logic [3:0] ic, ra, rb, input logic c,
                         output logic [3:0] sa, sb, de, dm);
        sa = 4'hF; sb = 4'hF; de = 4'hF; dm = 4'hF;
        case (ic)
            4'h2: begin sa = ra; de = c ? rb : 4'hF; end
            4'h3: de = rb;
            4'h4: begin sa = ra; sb = rb; end
            4'h5: begin sb = rb; dm = ra; end
            4'h6: begin sa = ra; sb = rb; de = rb; end
            4'h8: begin sb = 4; de = 4; end
            4'h9: begin sa = 4; sb = 4; de = 4; end
            4'hA: begin sa = ra; sb = 4; de = 4; end
            4'hB: begin sa = 4; sb = 4; de = 4; dm = ra; end
            default: ;
        endcase
    endtask

    task automatic cyc(input logic [3:0] ic, ra, rb,
                       input logic v, c, w,
                       input logic [63:0] ve, vm);
        exp_t x;
        logic [3:0] sa, sb, de, dm;
        m_sel(ic, ra, rb, c, sa, sb, de, dm);
        icode = ic; rA = ra; rB = rb; instr_valid = v;
        cnd = c; wb_en = w; valE = ve; valM = vm;
        if (v) begin
            m_a0 = m_rd(sa);
            m_b0 = m_rd(sb);
            m_a1 = m_byp(sa, w, m_a0, ve, vm);
            m_b1 = m_byp(sb, w, m_b0, ve, vm);
        end
        if (w) begin
            if (m_e != 4'hF) mrf[m_e] = ve;
            if (m_m != 4'hF) mrf[m_m] = vm;
        end
        m_e = v ? de : 4'hF;
        m_m = v ? dm : 4'hF;
        x.a1 = m_a1; x.a0 = m_a0; x.b1 = m_b1; x.b0 = m_b0;
        x.e = m_e; x.m = m_m;
        scb.push_back(x);
        @(posedge clk);
        #1;
        x = scb.pop_front();
        chk("valA", va1, x.a1);
        chk("valA_nobyp", va0, x.a0);
        chk("valB", vb1, x.b1);
        chk("valB_nobyp", vb0, x.b0);
        chk("dstE", {60'd0, de1}, {60'd0, x.e});
        chk("dstM", {60'd0, dm1}, {60'd0, x.m});
        chk("dstE_nobyp", {60'd0, de0}, {60'd0, x.e});
        chk("dstM_nobyp", {60'd0, dm0}, {60'd0, x.m});
    endtask

    task automatic dbg(input logic [3:0] a, input logic [63:0] exp);
        dbg_addr = a;
        #1;
        chk("dbg_data", dd1, exp);
        chk("dbg_data_nobyp", dd0, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        icode = 0; rA = 4'hF; rB = 4'hF; instr_valid = 0;
        cnd = 0; wb_en = 0; valE = 0; valM = 0; dbg_addr = 0;
        m_reset();
        #12;
        dbg(4, 64'h200);
        dbg(0, 64'd0);
        dbg(4'hF, 64'd0);
        chk("rst_valA", va1, 64'd0);
        chk("rst_valB", vb1, 64'd0);
        chk("rst_dstE", {60'd0, de1}, 64'hF);
        chk("rst_dstM", {60'd0, dm1}, 64'hF);
        reset_n = 1'b1;

        // irmovq $1, %rax
        cyc(4'h3, 4'hF, 4'h0, 1, 0, 0, 0, 0);
        cyc(4'h1, 4'hF, 4'hF, 0, 0, 1, 64'h1, 64'h0);
        dbg(0, 64'h1);

        // pushq %rax
        cyc(4'hA, 4'h0, 4'hF, 1, 0, 0, 0, 0);
        cyc(4'h1, 4'hF, 4'hF, 0, 0, 1, 64'h1F8, 64'h0);
        dbg(4, 64'h1F8);

        // popq %rsp: M wins over E
        cyc(4'hB, 4'h4, 4'hF, 1, 0, 0, 0, 0);
        cyc(4'h1, 4'hF, 4'hF, 0, 0, 1, 64'h208, 64'hDEAD);
        dbg(4, 64'hDEAD);

        // cmovXX not taken, then taken
        cyc(4'h2, 4'h0, 4'h3, 1, 0, 0, 0, 0);
        cyc(4'h1, 4'hF, 4'hF, 0, 0, 1, 64'h55, 64'h0);
        dbg(3, 64'd0);
        cyc(4'h2, 4'h0, 4'h3, 1, 1, 0, 0, 0);
        cyc(4'h1, 4'hF, 4'hF, 0, 0, 1, 64'h55, 64'h0);
        dbg(3, 64'h55);

        // opq reads reg0 on the edge that writes it
        cyc(4'h3, 4'hF, 4'h0, 1, 0, 0, 0, 0);
        cyc(4'h6, 4'h0, 4'h3, 1, 0, 1, 64'h7, 64'h0);
        chk("byp_valA", va1, 64'h7);
        chk("nobyp_valA", va0, 64'h1);
        dbg(0, 64'h7);

        // unknown icode reads and writes nothing
        cyc(4'hC, 4'h0, 4'h3, 1, 1, 0, 0, 0);
        cyc(4'h1, 4'hF, 4'hF, 0, 0, 1, 64'h99, 64'h98);
        dbg(0, 64'h7);

        for (int i = 0; i < 60; i++)
            cyc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, {$urandom, $urandom});
        for (int a = 0; a < 16; a++)
            dbg(4'(a), m_rd(4'(a)));

        // async reset mid-cycle with a writeback pending
        cyc(4'hA, 4'h0, 4'hF, 1, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        m_reset();
        chk("midrst_valA", va1, 64'd0);
        chk("midrst_valB", vb1, 64'd0);
        chk("midrst_dstE", {60'd0, de1}, 64'hF);
        chk("midrst_dstM", {60'd0, dm1}, 64'hF);
        dbg(4, 64'h200);
        reset_n = 1'b1;
        cyc(4'h1, 4'hF, 4'hF, 0, 0, 1, 64'h77, 64'h66);
        dbg(4, 64'h200);
        dbg(0, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
